// File: rtl/mem_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_game_pkg
// Purpose  : Shared types and constants for the Memory Sequence Game
//            password path: the password-change FSM states, slot geometry
//            and the digit type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_game_pkg;

  localparam int PW_LEN      = 6;  // digits per player password
  localparam int SLOT_STRIDE = 8;  // address distance between player slots
  localparam int MAX_SLOT    = 5;  // highest legal slot index

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } pw_state_t;

endpackage
`default_nettype wire

// File: rtl/pw_digit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pw_digit_buffer
// Purpose  : Small register file holding the password being entered, with a
//            wrapping index counter shared by load (ENTER) and compare
//            (CONFIRM) modes, plus an independent read port for WRITE.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clr             - return index to 0
//            load            - store digit at index, advance index
//            cmp             - advance index (compare result on eq)
//            digit           - incoming digit
//            rd_idx, rd_data - random read port
//            eq              - stored digit at index equals digit
//            last            - index points at the final entry
// Revision : 1.0 - initial release
// ============================================================================
module pw_digit_buffer
  import mem_game_pkg::*;
#(
  parameter int DEPTH = PW_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       cmp,
  input  logic [3:0] digit,
  input  logic [2:0] rd_idx,
  output logic       eq,
  output logic       last,
  output logic [3:0] rd_data
);

  localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);

  digit_t     r_buf [DEPTH];
  logic [2:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (clr) begin
        r_idx <= 3'd0;
      end else if (load || cmp) begin
        // Wrap after the last entry so the next phase starts at index 0.
        r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
      end
      if (load && !clr) begin
        r_buf[r_idx] <= digit;
      end
    end
  end

  assign eq      = (r_buf[r_idx] == digit);
  assign last    = (r_idx == LAST_IDX);
  assign rd_data = r_buf[rd_idx];

endmodule
`default_nettype wire

// File: rtl/password_writer.sv
`default_nettype none
// ============================================================================
// Module   : password_writer
// Purpose  : Password-change engine. A logged-in player enters a new password
//            twice; on a match the digits are written into the player's RAM
//            slot and the slot is marked valid.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            LoggedIn, AddrBegin    - player session and slot base address
//            ChangeReq              - start pulse
//            PasswordEnter/Digit    - digit strobe and value
//            Addr, DataOut, wr      - RAM write port
//            Busy, Done, Fail       - status
//            UseRAM                 - RAM password valid for AddrBegin's slot
// Revision : 1.0 - initial release
// ============================================================================
module password_writer
  import mem_game_pkg::*;
#(
  parameter int PW_LEN      = mem_game_pkg::PW_LEN,
  parameter int SLOT_STRIDE = mem_game_pkg::SLOT_STRIDE,
  parameter int MAX_SLOT    = mem_game_pkg::MAX_SLOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LoggedIn,
  input  logic [5:0] AddrBegin,
  input  logic       ChangeReq,
  input  logic       PasswordEnter,
  input  logic [3:0] PasswordDigit,
  output logic [5:0] Addr,
  output logic [3:0] DataOut,
  output logic       wr,
  output logic       Busy,
  output logic       Done,
  output logic       Fail,
  output logic       UseRAM
);

  localparam int         SLOT_LSB     = $clog2(SLOT_STRIDE);
  localparam logic [2:0] LAST_IDX     = 3'(PW_LEN - 1);
  localparam logic [2:0] MAX_SLOT_IDX = 3'(MAX_SLOT);

  pw_state_t  r_state, w_next;
  logic [5:0] r_base;
  logic [2:0] r_slot;
  logic       r_mismatch, w_mismatch_n;
  logic [2:0] r_wcnt, w_wcnt_n;
  logic [7:0] r_valid;
  logic       w_set_valid;

  logic       w_buf_clr, w_buf_load, w_buf_cmp;
  logic       w_buf_eq, w_buf_last;
  logic [3:0] w_rd_data;
  logic [2:0] w_slot_in;
  logic       w_start;

  logic [5:0] r_addr;
  logic [3:0] r_data;
  logic       r_wr, r_busy, r_done, r_fail, r_use_ram;

  assign w_slot_in = AddrBegin[SLOT_LSB +: 3];
  assign w_start   = (r_state == ST_IDLE) && ChangeReq && LoggedIn;

  pw_digit_buffer #(.DEPTH(PW_LEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_buf_clr),
    .load    (w_buf_load),
    .cmp     (w_buf_cmp),
    .digit   (PasswordDigit),
    .rd_idx  (w_wcnt_n),
    .eq      (w_buf_eq),
    .last    (w_buf_last),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus datapath controls. Outputs are registered from the next
  // state, so each output appears in the same cycle as the state it belongs to.
  always_comb begin
    w_next       = r_state;
    w_buf_clr    = 1'b0;
    w_buf_load   = 1'b0;
    w_buf_cmp    = 1'b0;
    w_mismatch_n = r_mismatch;
    w_wcnt_n     = r_wcnt;
    w_set_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_slot_in > MAX_SLOT_IDX) begin
            w_next = ST_FAIL;
          end else begin
            w_next    = ST_ENTER;
            w_buf_clr = 1'b1;
          end
        end
      end
      ST_ENTER: begin
        if (!LoggedIn) begin
          w_next = ST_FAIL;
        end else if (PasswordEnter) begin
          w_buf_load = 1'b1;
          if (w_buf_last) begin
            w_next       = ST_CONFIRM;
            w_mismatch_n = 1'b0;
          end
        end
      end
      ST_CONFIRM: begin
        if (!LoggedIn) begin
          w_next = ST_FAIL;
        end else if (PasswordEnter) begin
          w_buf_cmp = 1'b1;
          if (!w_buf_eq) w_mismatch_n = 1'b1;
          if (w_buf_last) begin
            if (r_mismatch || !w_buf_eq) begin
              w_next = ST_FAIL;
            end else begin
              w_next   = ST_WRITE;
              w_wcnt_n = 3'd0;
            end
          end
        end
      end
      ST_WRITE: begin
        // Valid is set on the last write so UseRAM follows one cycle after DONE.
        if (r_wcnt == LAST_IDX) begin
          w_next      = ST_DONE;
          w_set_valid = 1'b1;
        end else begin
          w_wcnt_n = r_wcnt + 3'd1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      ST_FAIL: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base     <= 6'd0;
      r_slot     <= 3'd0;
      r_mismatch <= 1'b0;
      r_wcnt     <= 3'd0;
      r_valid    <= 8'd0;
      r_addr     <= 6'd0;
      r_data     <= 4'd0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_use_ram  <= 1'b0;
    end else begin
      if (w_start) begin
        r_base <= AddrBegin;
        r_slot <= w_slot_in;
      end
      r_mismatch <= w_mismatch_n;
      r_wcnt     <= w_wcnt_n;
      if (w_set_valid) r_valid[r_slot] <= 1'b1;

      r_wr   <= (w_next == ST_WRITE);
      r_addr <= (w_next == ST_WRITE) ? r_base + {3'b000, w_wcnt_n} : 6'd0;
      r_data <= (w_next == ST_WRITE) ? w_rd_data : 4'd0;
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
      r_fail <= (w_next == ST_FAIL);
      r_use_ram <= (w_slot_in <= MAX_SLOT_IDX) && r_valid[w_slot_in];
    end
  end

  assign Addr    = r_addr;
  assign DataOut = r_data;
  assign wr      = r_wr;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Fail    = r_fail;
  assign UseRAM  = r_use_ram;

endmodule
`default_nettype wire

// File: tb/tb_password_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_writer
// Purpose  : Self-checking bench for password_writer. Inputs change on the
//            falling edge, outputs are sampled on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       LoggedIn;
  logic [5:0] AddrBegin;
  logic       ChangeReq;
  logic       PasswordEnter;
  logic [3:0] PasswordDigit;
  logic [5:0] Addr;
  logic [3:0] DataOut;
  logic       wr, Busy, Done, Fail, UseRAM;

  always #5 clk = ~clk;

  password_writer dut (
    .clk           (clk),
    .rst           (rst),
    .LoggedIn      (LoggedIn),
    .AddrBegin     (AddrBegin),
    .ChangeReq     (ChangeReq),
    .PasswordEnter (PasswordEnter),
    .PasswordDigit (PasswordDigit),
    .Addr          (Addr),
    .DataOut       (DataOut),
    .wr            (wr),
    .Busy          (Busy),
    .Done          (Done),
    .Fail          (Fail),
    .UseRAM        (UseRAM)
  );

  int total  = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       li;
    logic [5:0] ab;
    logic       cr;
    logic       pe;
    logic [3:0] d;
    logic       wr;
    logic [5:0] addr;
    logic [3:0] dout;
    logic       busy;
    logic       done;
    logic       fail;
    logic       use_ram;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic li, input logic [5:0] ab, input logic cr,
                     input logic pe, input logic [3:0] d, input logic e_wr,
                     input logic [5:0] e_addr, input logic [3:0] e_dout,
                     input logic e_busy, input logic e_done, input logic e_fail,
                     input logic e_use);
    vec_t v;
    v.li = li; v.ab = ab; v.cr = cr; v.pe = pe; v.d = d;
    v.wr = e_wr; v.addr = e_addr; v.dout = e_dout;
    v.busy = e_busy; v.done = e_done; v.fail = e_fail; v.use_ram = e_use;
    tbl.push_back(v);
  endtask

  // ---------------- sequence helpers ----------------
  int         g_base;
  int         g_wr, g_done, g_fail;
  logic [3:0] g_exp [6];

  task automatic cyc(input logic li, input logic [5:0] ab, input logic cr,
                     input logic pe, input logic [3:0] d);
    LoggedIn = li; AddrBegin = ab; ChangeReq = cr;
    PasswordEnter = pe; PasswordDigit = d;
    @(posedge clk);
    @(negedge clk);
    if (wr) begin
      if (g_wr < 6) begin
        chk("seq_wr_addr", 32'(Addr), 32'(g_base + g_wr));
        chk("seq_wr_data", 32'(DataOut), 32'(g_exp[g_wr]));
      end
      g_wr++;
    end
    if (Done) g_done++;
    if (Fail) g_fail++;
  endtask

  task automatic seq_reset(input int base, input logic [23:0] digits);
    g_base = base; g_wr = 0; g_done = 0; g_fail = 0;
    for (int i = 0; i < 6; i++) g_exp[i] = digits[23 - 4*i -: 4];
  endtask

  task automatic run_change(input logic [5:0] ab, input logic [23:0] ent,
                            input logic [23:0] cnf);
    seq_reset(int'(ab), ent);
    cyc(1'b1, ab, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, ab, 1'b0, 1'b1, ent[23 - 4*i -: 4]);
    for (int i = 0; i < 6; i++) cyc(1'b1, ab, 1'b0, 1'b1, cnf[23 - 4*i -: 4]);
    repeat (9) cyc(1'b1, ab, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    logic [3:0] mm_conf [6];
    logic [3:0] mm_ent  [6];

    rst = 1'b1; LoggedIn = 1'b0; AddrBegin = 6'd0; ChangeReq = 1'b0;
    PasswordEnter = 1'b0; PasswordDigit = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", 32'(Addr), 0);
    chk("rst_dout", 32'(DataOut), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_fail", 32'(Fail), 0);
    chk("rst_useram", 32'(UseRAM), 0);
    rst = 1'b0;

    // Slot 0: strobe in IDLE, strobe with ChangeReq, ChangeReq in CONFIRM.
    add(1, 6'd0, 0, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6'd0, 1, 1, 4'd7, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) add(1, 6'd0, 0, 1, 4'(i), 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 6'd0, (i == 3), 1, 4'(i), 0, 0, 0, 1, 0, 0, 0);
    add(1, 6'd0, 0, 1, 4'd6, 1, 6'd0, 4'd1, 1, 0, 0, 0);          // C -> write 0
    for (int k = 1; k <= 5; k++) add(1, 6'd0, 0, 0, 4'd0, 1, 6'(k), 4'(k + 1), 1, 0, 0, 0);
    add(1, 6'd0, 0, 0, 4'd0, 0, 0, 0, 1, 1, 0, 0);                // C+7 Done
    add(1, 6'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);                // C+8 UseRAM
    add(1, 6'd8, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6'd0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1);

    // Slot 2: mismatch only on the 6th digit.
    mm_ent  = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
    mm_conf = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd3};
    add(1, 6'd16, 1, 0, 4'd0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 6'd16, 0, 1, mm_ent[i], 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 6'd16, 0, 1, mm_conf[i], 0, 0, 0, 1, 0, 0, 0);
    add(1, 6'd16, 0, 1, mm_conf[5], 0, 0, 0, 1, 0, 1, 0);         // C+1 Fail
    add(1, 6'd16, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);                // C+2 idle
    add(1, 6'd16, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal slot 6.
    add(1, 6'd48, 1, 0, 4'd0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 6'd48, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6'd48, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      LoggedIn = tbl[i].li; AddrBegin = tbl[i].ab; ChangeReq = tbl[i].cr;
      PasswordEnter = tbl[i].pe; PasswordDigit = tbl[i].d;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r%0d_wr", i), 32'(wr), 32'(tbl[i].wr));
      chk($sformatf("r%0d_busy", i), 32'(Busy), 32'(tbl[i].busy));
      chk($sformatf("r%0d_done", i), 32'(Done), 32'(tbl[i].done));
      chk($sformatf("r%0d_fail", i), 32'(Fail), 32'(tbl[i].fail));
      chk($sformatf("r%0d_useram", i), 32'(UseRAM), 32'(tbl[i].use_ram));
      if (tbl[i].wr) begin
        chk($sformatf("r%0d_addr", i), 32'(Addr), 32'(tbl[i].addr));
        chk($sformatf("r%0d_dout", i), 32'(DataOut), 32'(tbl[i].dout));
      end
    end

    // Abort: LoggedIn drops after 3 confirm digits, with a strobe that cycle.
    seq_reset(24, 24'h112233);
    cyc(1'b1, 6'd24, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'd24, 1'b0, 1'b1, g_exp[i]);
    for (int i = 0; i < 3; i++) cyc(1'b1, 6'd24, 1'b0, 1'b1, g_exp[i]);
    cyc(1'b0, 6'd24, 1'b0, 1'b1, g_exp[3]);
    chk("abort_fail", 32'(Fail), 1);
    repeat (8) cyc(1'b0, 6'd24, 1'b0, 1'b0, 4'd0);
    chk("abort_no_wr", 32'(g_wr), 0);
    chk("abort_no_done", 32'(g_done), 0);
    chk("abort_fail_cnt", 32'(g_fail), 1);
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_useram", 32'(UseRAM), 0);

    // LoggedIn drops during WRITE cycle 2: all writes still complete.
    seq_reset(40, 24'h246801);
    cyc(1'b1, 6'd40, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'd40, 1'b0, 1'b1, g_exp[i]);
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'd40, 1'b0, 1'b1, g_exp[i]);
    cyc(1'b1, 6'd40, 1'b0, 1'b0, 4'd0);
    repeat (8) cyc(1'b0, 6'd40, 1'b0, 1'b0, 4'd0);
    chk("wrdrop_writes", 32'(g_wr), 6);
    chk("wrdrop_done", 32'(g_done), 1);
    chk("wrdrop_fail", 32'(g_fail), 0);
    chk("wrdrop_useram", 32'(UseRAM), 1);

    // Two successful changes, then reset clears validity.
    run_change(6'd8, 24'h135790, 24'h135790);
    chk("s1_writes", 32'(g_wr), 6);
    chk("s1_done", 32'(g_done), 1);
    run_change(6'd32, 24'h864208, 24'h864208);
    chk("s4_writes", 32'(g_wr), 6);
    chk("s4_done", 32'(g_done), 1);
    cyc(1'b1, 6'd8, 1'b0, 1'b0, 4'd0);
    chk("s1_useram", 32'(UseRAM), 1);
    cyc(1'b1, 6'd32, 1'b0, 1'b0, 4'd0);
    chk("s4_useram", 32'(UseRAM), 1);
    rst = 1'b1;
    cyc(1'b1, 6'd32, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    cyc(1'b1, 6'd8, 1'b0, 1'b0, 4'd0);
    chk("s1_useram_rst", 32'(UseRAM), 0);
    cyc(1'b1, 6'd32, 1'b0, 1'b0, 4'd0);
    chk("s4_useram_rst", 32'(UseRAM), 0);

    // Reset after the second write halts the burst.
    seq_reset(24, 24'h777777);
    cyc(1'b1, 6'd24, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'd24, 1'b0, 1'b1, 4'd7);
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'd24, 1'b0, 1'b1, 4'd7);
    cyc(1'b1, 6'd24, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    cyc(1'b1, 6'd24, 1'b0, 1'b0, 4'd0);
    chk("midrst_wr", 32'(wr), 0);
    chk("midrst_busy", 32'(Busy), 0);
    rst = 1'b0;
    repeat (6) cyc(1'b1, 6'd24, 1'b0, 1'b0, 4'd0);
    chk("midrst_writes", 32'(g_wr), 2);
    chk("midrst_done", 32'(g_done), 0);
    chk("midrst_useram", 32'(UseRAM), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/password_writer.md
# password_writer

Password-change engine for the Memory Sequence Game login path. It is the write side of the player password RAM that the authentication FSM reads. A logged-in player requests a change, enters a new 6-digit password, then confirms it. On a match the block writes the digits into the player's RAM slot and marks that slot valid. `UseRAM` tells the authentication side whether to compare against RAM or ROM.

## Interface
Parameters:
- `PW_LEN`, 6: password digits per player.
- `SLOT_STRIDE`, 8: address stride between player slots.
- `MAX_SLOT`, 5: highest legal slot index (base address 40).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `LoggedIn`  in  1  player currently authenticated.
- `AddrBegin`  in  6  base address of the logged-in player's slot.
- `ChangeReq`  in  1  one-cycle pulse that starts a change.
- `PasswordEnter`  in  1  one-cycle digit strobe (already debounced).
- `PasswordDigit`  in  4  digit value, sampled when `PasswordEnter`=1.
- `Addr`  out  6  RAM address.
- `DataOut`  out  4  RAM write data.
- `wr`  out  1  RAM write enable.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse on successful write.
- `Fail`  out  1  one-cycle pulse on mismatch, abort or illegal slot.
- `UseRAM`  out  1  RAM password valid for the slot of the current `AddrBegin`.

## Operation
- States: IDLE, ENTER, CONFIRM, WRITE, DONE, FAIL. All outputs are registered.
- IDLE
  - `ChangeReq`=1 and `LoggedIn`=1: latch base=`AddrBegin` and slot=`AddrBegin[5:3]`.
  - If slot > `MAX_SLOT`, go to FAIL; otherwise go to ENTER with idx=0.
  - A `PasswordEnter` pulse in IDLE, or in the same cycle as `ChangeReq`, is ignored.
- ENTER: each strobe stores the digit in buf[idx] and increments idx. After the 6th digit: idx=0, mismatch=0, go to CONFIRM.
- CONFIRM: each strobe compares the digit with buf[idx] and sets the sticky mismatch flag on inequality. After the 6th digit: go to WRITE if mismatch=0 (including the 6th compare), else go to FAIL.
- WRITE: for i=0..5, `wr`=1, `Addr`=base+i, `DataOut`=buf[i]. After i=5, go to DONE.
- DONE: `Done`=1, set valid[slot], go to IDLE.
- FAIL: `Fail`=1, go to IDLE. The buffer and valid bits are unchanged.
- Abort: `LoggedIn`=0 in ENTER or CONFIRM sends the block to FAIL; digits received in that cycle are dropped.
- `LoggedIn` is ignored during WRITE and DONE, so a slot is never left half-written.
- `ChangeReq` is ignored outside IDLE.
- `UseRAM` is registered each cycle from valid[`AddrBegin[5:3]`]; it is 0 for slot > `MAX_SLOT`. The valid bits clear only on `rst`.
- Address arithmetic is 6-bit. base+5 ≤ 45 for legal slots, so it never wraps.

## Timing
- Reset values: `Addr`=0, `DataOut`=0, `wr`=0, `Busy`=0, `Done`=0, `Fail`=0, `UseRAM`=0. State=IDLE, all valid bits=0, buffer=0.
- Reset mid-WRITE stops writing on the next edge. The slot keeps its partial contents, and valid stays 0 (cleared).
- `ChangeReq` at cycle T sets `Busy`=1 at T+1.
- 6th confirm strobe at cycle C gives:
  - `wr`=1 at C+1..C+6 (6 consecutive cycles, no gaps);
  - `Done`=1 at C+7;
  - `Busy`=0 and `UseRAM` updated at C+8.
- A mismatch gives `Fail`=1 at C+1 and `Busy`=0 at C+2.
- An illegal slot at T gives `Fail`=1 at T+1.
- Strobes may arrive back-to-back, one per cycle; there is no minimum spacing.

## Structure
- Shared package `mem_game_pkg` holds:
  - the state enum;
  - `PW_LEN`, `SLOT_STRIDE` and `MAX_SLOT`;
  - a 4-bit digit typedef.
- One natural sub-module, `pw_digit_buffer`: a 6×4 register file with a 3-bit index counter and load/compare/read modes, used by ENTER, CONFIRM and WRITE. The top-level FSM, slot latch and valid bits stay in `password_writer`.

## Test plan
- Slot 0 (`AddrBegin`=0), enter 1-2-3-4-5-6, confirm 1-2-3-4-5-6 → `wr` high for 6 cycles at `Addr` 0..5 with `DataOut` 1..6; `Done` pulses; `UseRAM`=1.
- Slot 2 (`AddrBegin`=16), enter 9-8-7-6-5-4, confirm 9-8-7-6-5-3 → no `wr`; `Fail` at C+1; `UseRAM` for 16 stays 0.
- `AddrBegin`=48 with `ChangeReq` → `Fail` next cycle, no `wr`, `Busy` low after 2 cycles.
- Drop `LoggedIn` after 3 confirm digits → `Fail`, no `wr`. Drop `LoggedIn` during WRITE cycle 2 → all 6 writes complete and `Done` pulses.
- Two successful changes on slots 1 and 4, then `rst` pulse → `UseRAM`=0 for `AddrBegin` 8 and 32. `ChangeReq` during CONFIRM is ignored. Digit strobe coincident with `ChangeReq` is not stored.
